// File: rtl/map_loader_pkg.sv
// Shared definitions for the map loader: FSM encoding, level limits,
// default geometry and the row address width used by the ROM interface.
package map_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int ROWS_DEFAULT  = 8;
    localparam int WIDTH_DEFAULT = 8;
    localparam int ADDR_W        = 3;
    localparam int LEVEL_W       = 2;

    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 2'd2;

endpackage

// File: rtl/map_loader_tagpipe.sv
// Valid + row-address shift register that travels alongside each ROM read,
// so the returning data can be matched to the row it belongs to.
module map_loader_tagpipe
    import map_loader_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr
);

    logic [DEPTH-1:0]  valid_sr;
    logic [ADDR_W-1:0] addr_sr [DEPTH];

    // Shift tags one stage per cycle; reset drops any in-flight requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_sr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_sr[i] <= '0;
            end
        end else begin
            valid_sr[0] <= in_valid;
            addr_sr[0]  <= in_addr;
            for (int i = 1; i < DEPTH; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                addr_sr[i]  <= addr_sr[i-1];
            end
        end
    end

    assign out_valid = valid_sr[DEPTH-1];
    assign out_addr  = addr_sr[DEPTH-1];

endmodule

// File: rtl/map_loader.sv
// Map loader: fetches ROWS rows of a selected level map from a pipelined
// ROM into a local row buffer and serves registered single-cell wall queries.
// Optional feature macro: MAP_LOADER_CHECKSUM_EN enables the XOR checksum
// accumulator; when undefined the checksum port is tied to zero.
module map_loader
    import map_loader_pkg::*;
#(
    parameter int ROM_LATENCY = 2,
    parameter int ROWS        = ROWS_DEFAULT,
    parameter int WIDTH       = WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [LEVEL_W-1:0] level,
    output logic [LEVEL_W-1:0] rom_sel,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [WIDTH-1:0]   rom_data,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               map_valid,
    input  logic [2:0]         cell_x,
    input  logic [2:0]         cell_y,
    output logic               cell_wall,
    output logic [WIDTH-1:0]   checksum
);

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

    state_t              state;
    state_t              next_state;
    logic [ADDR_W-1:0]   addr_cnt;
    logic [LEVEL_W-1:0]  sel_q;
    logic                err_q;
    logic                valid_q;
    logic                wall_q;
    logic [WIDTH-1:0]    rows [ROWS];

    logic                accept;
    logic                reject;
    logic                issue_valid;
    logic                tag_valid;
    logic [ADDR_W-1:0]   tag_addr;
    logic                last_back;

    map_loader_tagpipe #(
        .DEPTH (ROM_LATENCY)
    ) u_tagpipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (issue_valid),
        .in_addr   (addr_cnt),
        .out_valid (tag_valid),
        .out_addr  (tag_addr)
    );

    assign last_back = tag_valid && (tag_addr == LAST_ROW);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and per-state control decode
    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        reject      = 1'b0;
        issue_valid = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (level <= LEVEL_MAX) begin
                        accept     = 1'b1;
                        next_state = ST_ISSUE;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                busy        = 1'b1;
                issue_valid = 1'b1;
                if (addr_cnt == LAST_ROW) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (last_back) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Row address counter: walks rows while issuing, parks at 0 otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_cnt <= '0;
        end else if (state == ST_ISSUE && addr_cnt != LAST_ROW) begin
            addr_cnt <= addr_cnt + ADDR_W'(1);
        end else begin
            addr_cnt <= '0;
        end
    end

    // Level select, error pulse and map-complete flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            err_q <= reject;
            if (accept) begin
                sel_q   <= level;
                valid_q <= 1'b0;
            end else if (state == ST_DRAIN && last_back) begin
                valid_q <= 1'b1;
            end
        end
    end

    // Row buffer: ROM data lands in the row its returning tag names
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROWS; i++) begin
                rows[i] <= '0;
            end
        end else if (tag_valid) begin
            rows[tag_addr] <= rom_data;
        end
    end

    // Registered cell query against the current buffer contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wall_q <= 1'b0;
        end else begin
            wall_q <= rows[cell_y][cell_x];
        end
    end

`ifdef MAP_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0] sum_q;

    // Running XOR of every captured row, restarted by each accepted load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= '0;
        end else if (tag_valid) begin
            sum_q <= sum_q ^ rom_data;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

    assign rom_sel   = sel_q;
    assign rom_addr  = addr_cnt;
    assign err       = err_q;
    assign map_valid = valid_q;
    assign cell_wall = wall_q;

endmodule

// File: tb/tb_map_loader.sv
// Self-checking bench for map_loader: pipelined ROM model, randomized map
// contents and level sequence, checked against a row-array reference model.
module tb_map_loader;

    localparam int ROM_LAT = 2;
    localparam int ROWS    = 8;
    localparam int WIDTH   = 8;
    localparam int LOAD_CYCLES = 1 + ROWS + ROM_LAT;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [1:0]       level;
    logic [1:0]       rom_sel;
    logic [2:0]       rom_addr;
    logic [WIDTH-1:0] rom_data;
    logic             busy;
    logic             done;
    logic             err;
    logic             map_valid;
    logic [2:0]       cell_x;
    logic [2:0]       cell_y;
    logic             cell_wall;
    logic [WIDTH-1:0] checksum;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] rom_mem  [0:3][0:ROWS-1];
    logic [WIDTH-1:0] rom_pipe [ROM_LAT];
    logic [WIDTH-1:0] ref_rows [ROWS];
    logic             ref_valid;

    map_loader #(
        .ROM_LATENCY (ROM_LAT),
        .ROWS        (ROWS),
        .WIDTH       (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .level     (level),
        .rom_sel   (rom_sel),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .map_valid (map_valid),
        .cell_x    (cell_x),
        .cell_y    (cell_y),
        .cell_wall (cell_wall),
        .checksum  (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered map ROM: data for an address appears ROM_LAT cycles later
    always @(posedge clk) begin
        rom_pipe[0] <= rom_mem[rom_sel][rom_addr];
        for (int i = 1; i < ROM_LAT; i++) begin
            rom_pipe[i] <= rom_pipe[i-1];
        end
    end
    assign rom_data = rom_pipe[ROM_LAT-1];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] expSum(input int lvl);
        logic [WIDTH-1:0] s;
        s = '0;
`ifdef MAP_LOADER_CHECKSUM_EN
        for (int r = 0; r < ROWS; r++) s ^= rom_mem[lvl][r];
`endif
        return s;
    endfunction

    // One-cycle start pulse; returns at the negedge of the first cycle after acceptance
    task automatic applyStimulus(input logic [1:0] lvl);
        start = 1'b1;
        level = lvl;
        @(negedge clk);
        start = 1'b0;
        level = 2'($urandom);
    endtask

    task automatic runLoad(input logic [1:0] lvl, input bit restart);
        int cyc;
        applyStimulus(lvl);
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            checkOutput($sformatf("rom_addr c%0d", cyc), rom_addr, (cyc <= ROWS) ? cyc - 1 : 0);
            checkOutput("rom_sel load", rom_sel, lvl);
            checkOutput("busy load", busy, 1);
            checkOutput("map_valid load", map_valid, 0);
            if (restart && cyc == 3) begin
                start = 1'b1;
                level = 2'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        checkOutput("latency", cyc, LOAD_CYCLES);
        checkOutput("done", done, 1);
        checkOutput("busy at done", busy, 0);
        checkOutput("map_valid at done", map_valid, 1);
        checkOutput("rom_addr at done", rom_addr, 0);
        checkOutput("checksum at done", checksum, expSum(lvl));
        for (int r = 0; r < ROWS; r++) ref_rows[r] = rom_mem[lvl][r];
        ref_valid = 1'b1;
        @(negedge clk);
        checkOutput("done pulse width", done, 0);
        checkOutput("busy after done", busy, 0);
        checkOutput("rom_sel after load", rom_sel, lvl);
    endtask

    task automatic verifyRows();
        for (int y = 0; y < ROWS; y++) begin
            for (int x = 0; x < WIDTH; x++) begin
                cell_x = 3'(x);
                cell_y = 3'(y);
                @(negedge clk);
                checkOutput($sformatf("cell_wall y%0d x%0d", y, x), cell_wall, ref_rows[y][x]);
            end
        end
        checkOutput("map_valid idle", map_valid, ref_valid);
    endtask

    task automatic errorLoad();
        start = 1'b1;
        level = 2'd3;
        @(negedge clk);
        start = 1'b0;
        checkOutput("err pulse", err, 1);
        checkOutput("busy on err", busy, 0);
        @(negedge clk);
        checkOutput("err cleared", err, 0);
        checkOutput("busy after err", busy, 0);
        checkOutput("map_valid kept", map_valid, ref_valid);
    endtask

    task automatic checkZeroOutputs(input string tag);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " done"}, done, 0);
        checkOutput({tag, " err"}, err, 0);
        checkOutput({tag, " map_valid"}, map_valid, 0);
        checkOutput({tag, " cell_wall"}, cell_wall, 0);
        checkOutput({tag, " rom_sel"}, rom_sel, 0);
        checkOutput({tag, " rom_addr"}, rom_addr, 0);
        checkOutput({tag, " checksum"}, checksum, 0);
    endtask

    initial begin
        logic [1:0] lvl;
        rst_n  = 1'b0;
        start  = 1'b0;
        level  = 2'd0;
        cell_x = 3'd0;
        cell_y = 3'd0;
        ref_valid = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            ref_rows[r]   = '0;
            rom_mem[0][r] = '0;
            rom_mem[1][r] = WIDTH'(r + 1);
            rom_mem[2][r] = WIDTH'($urandom);
            rom_mem[3][r] = WIDTH'($urandom);
        end
        rom_mem[0][0] = 8'hFF;
        rom_mem[0][1] = 8'h0F;
        rom_mem[0][7] = 8'hF0;
        rom_mem[2][3] = 8'h20;

        repeat (2) @(negedge clk);
        checkZeroOutputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        checkZeroOutputs("post reset");

        $display("[TB] level 1 load, rows 01..08");
        runLoad(2'd1, 1'b0);
        verifyRows();

        $display("[TB] illegal level rejected");
        errorLoad();
        verifyRows();

        $display("[TB] restart during load ignored");
        runLoad(2'd1, 1'b1);
        repeat (15) begin
            @(negedge clk);
            checkOutput("no second done", done, 0);
            checkOutput("rom_sel held", rom_sel, 1);
            checkOutput("idle busy", busy, 0);
        end

        $display("[TB] checksum pattern load");
        runLoad(2'd0, 1'b0);
        verifyRows();

        $display("[TB] cell query on row 3 = 20");
        runLoad(2'd2, 1'b0);
        cell_x = 3'd5;
        cell_y = 3'd3;
        @(negedge clk);
        checkOutput("wall x5 y3", cell_wall, 1);
        cell_x = 3'd4;
        @(negedge clk);
        checkOutput("wall x4 y3", cell_wall, 0);

        $display("[TB] reset mid-load");
        applyStimulus(2'd2);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkZeroOutputs("mid-load reset");
        #1;
        rst_n = 1'b1;
        for (int r = 0; r < ROWS; r++) ref_rows[r] = '0;
        ref_valid = 1'b0;
        repeat (ROM_LAT + 2) begin
            @(negedge clk);
            checkOutput("busy after reset", busy, 0);
            checkOutput("done after reset", done, 0);
        end
        verifyRows();

        $display("[TB] randomized load sequence");
        for (int n = 0; n < 8; n++) begin
            lvl = 2'($urandom_range(0, 3));
            if (lvl == 2'd3) begin
                errorLoad();
            end else begin
                for (int r = 0; r < ROWS; r++) rom_mem[lvl][r] = WIDTH'($urandom);
                runLoad(lvl, $urandom_range(0, 1) == 1);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (n % 3 == 2) verifyRows();
        end
        verifyRows();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
